pu_pass_sequencer: RTL and testbench

Multi-pass control and address-relocation front end for the processing unit. It queues pass descriptors, launches one processing-unit pass per descriptor and holds that pass's mapping configuration stable while it runs. It relocates all PU global-buffer addresses by per-pass base offsets, and applies optional ReLU on the registered opsum write-back path. It sits between the layer controller and the processing unit, so whole layers run as back-to-back passes without host intervention.

---
 rtl/pu_pass_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_pu_pass_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_pass_sequencer.sv
// pu_pass_sequencer
//   Multi-pass front end for the processing unit (PU). Queues pass
//   descriptors, launches one PU pass per descriptor, holds that pass's
//   mapping config and relocation bases in shadow registers while it runs,
//   relocates all PU global-buffer addresses, and applies optional ReLU on
//   the registered opsum write-back path.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   desc_valid/desc_ready      descriptor handshake
//   desc_cfg, desc_*_base      mapping word and relocation bases of a pass
//   desc_relu, desc_last       ReLU enable, final pass of the layer
//   pu_cfg, pu_start, pu_done  PU control (shadow config, start pulse, done)
//   pu_*_addr                  PU-relative GLB addresses
//   *_glb_addr                 relocated GLB read addresses (combinational)
//   pu_opsum_we/pu_opsum_data  PU opsum write-back
//   opsum_we_to_glb, opsum_glb_addr, opsum_to_glb  registered write-back
//   busy, layer_done, pass_count, cycle_count      status
module pu_pass_sequencer #(
   parameter int CFG_WIDTH       = 96,
   parameter int ADDR_WIDTH      = 20,
   parameter int DATA_WIDTH      = 16,
   parameter int DESC_FIFO_DEPTH = 4,
   parameter int PASS_CNT_WIDTH  = 8,
   parameter int CYC_CNT_WIDTH   = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      desc_valid,
   output logic                      desc_ready,
   input  logic [CFG_WIDTH-1:0]      desc_cfg,
   input  logic [ADDR_WIDTH-1:0]     desc_ifmap_base,
   input  logic [ADDR_WIDTH-1:0]     desc_filter_base,
   input  logic [ADDR_WIDTH-1:0]     desc_psum_base,
   input  logic                      desc_relu,
   input  logic                      desc_last,
   output logic [CFG_WIDTH-1:0]      pu_cfg,
   output logic                      pu_start,
   input  logic                      pu_done,
   input  logic [ADDR_WIDTH-1:0]     pu_ifmap_addr,
   input  logic [ADDR_WIDTH-1:0]     pu_filter_addr,
   input  logic [ADDR_WIDTH-1:0]     pu_ipsum_addr,
   input  logic [ADDR_WIDTH-1:0]     pu_bias_addr,
   input  logic [ADDR_WIDTH-1:0]     pu_opsum_addr,
   output logic [ADDR_WIDTH-1:0]     ifmap_glb_addr,
   output logic [ADDR_WIDTH-1:0]     filter_glb_addr,
   output logic [ADDR_WIDTH-1:0]     ipsum_glb_addr,
   output logic [ADDR_WIDTH-1:0]     bias_glb_addr,
   input  logic                      pu_opsum_we,
   input  logic [DATA_WIDTH-1:0]     pu_opsum_data,
   output logic                      opsum_we_to_glb,
   output logic [ADDR_WIDTH-1:0]     opsum_glb_addr,
   output logic [DATA_WIDTH-1:0]     opsum_to_glb,
   output logic                      busy,
   output logic                      layer_done,
   output logic [PASS_CNT_WIDTH-1:0] pass_count,
   output logic [CYC_CNT_WIDTH-1:0]  cycle_count
);

   localparam int PTR_W = $clog2(DESC_FIFO_DEPTH);

   typedef struct packed {
      logic [CFG_WIDTH-1:0]  cfg;
      logic [ADDR_WIDTH-1:0] ifmap_base;
      logic [ADDR_WIDTH-1:0] filter_base;
      logic [ADDR_WIDTH-1:0] psum_base;
      logic                  relu;
      logic                  last;
   } desc_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_RUN   = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   // ---------------------------------------------------------------
   // Descriptor FIFO. Pointers carry one extra wrap bit so full and
   // empty are distinguishable without a separate count.
   // ---------------------------------------------------------------
   desc_t            fifo_mem [DESC_FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr, rd_ptr;
   logic             fifo_empty, fifo_full;
   logic             push, pop;
   desc_t            desc_in;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   // Ready is a function of stored pointers only, so a pop in the same
   // cycle never opens a slot early. Masked while reset is held so all
   // outputs read 0 during reset; rises in the first cycle reset is low.
   assign desc_ready = !fifo_full && !reset;
   assign push       = desc_valid && desc_ready;

   assign desc_in = '{cfg:         desc_cfg,
                      ifmap_base:  desc_ifmap_base,
                      filter_base: desc_filter_base,
                      psum_base:   desc_psum_base,
                      relu:        desc_relu,
                      last:        desc_last};

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= desc_in;
   end

   // ---------------------------------------------------------------
   // Pass FSM
   // ---------------------------------------------------------------
   state_t state_q, state_d;
   logic   load_en, cc_inc, pass_step;
   desc_t  sh_q;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // pu_done only matters in RUN; elsewhere it is ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!fifo_empty) state_d = S_LOAD;
         S_LOAD:  state_d = S_START;
         S_START: state_d = S_RUN;
         S_RUN:   if (pu_done) state_d = S_DRAIN;
         S_DRAIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pu_start   = 1'b0;
      layer_done = 1'b0;
      load_en    = 1'b0;
      cc_inc     = 1'b0;
      pass_step  = 1'b0;
      case (state_q)
         S_LOAD:  load_en = 1'b1;
         S_START: begin
            pu_start = 1'b1;
            cc_inc   = 1'b1;
         end
         S_RUN:   cc_inc = 1'b1;
         S_DRAIN: begin
            pass_step  = 1'b1;
            layer_done = sh_q.last;
         end
         default: ;
      endcase
   end

   // LOAD is only entered with a non-empty FIFO, so it doubles as pop.
   assign pop = load_en;

   // ---------------------------------------------------------------
   // Shadow registers: the running pass sees only what LOAD captured.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset)        sh_q <= '0;
      else if (load_en) sh_q <= fifo_mem[rd_ptr[PTR_W-1:0]];
   end

   assign pu_cfg = sh_q.cfg;

   // ---------------------------------------------------------------
   // Address relocation (wraps modulo 2^ADDR_WIDTH). Bias lives in the
   // filter region, ipsum/opsum in the psum region.
   // ---------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] opsum_addr_rel;

   assign ifmap_glb_addr  = pu_ifmap_addr  + sh_q.ifmap_base;
   assign filter_glb_addr = pu_filter_addr + sh_q.filter_base;
   assign bias_glb_addr   = pu_bias_addr   + sh_q.filter_base;
   assign ipsum_glb_addr  = pu_ipsum_addr  + sh_q.psum_base;
   assign opsum_addr_rel  = pu_opsum_addr  + sh_q.psum_base;

   // ---------------------------------------------------------------
   // Opsum write-back stage. A write in the pu_done cycle lands in DRAIN,
   // still under this pass's shadow base and relu.
   // ---------------------------------------------------------------
   logic [DATA_WIDTH-1:0] opsum_data_act;

   assign opsum_data_act = (sh_q.relu && pu_opsum_data[DATA_WIDTH-1]) ?
                           '0 : pu_opsum_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         opsum_we_to_glb <= 1'b0;
         opsum_glb_addr  <= '0;
         opsum_to_glb    <= '0;
      end else begin
         opsum_we_to_glb <= pu_opsum_we;
         if (pu_opsum_we) begin
            opsum_glb_addr <= opsum_addr_rel;
            opsum_to_glb   <= opsum_data_act;
         end
      end
   end

   // ---------------------------------------------------------------
   // Counters. cycle_count saturates and keeps the last pass's length
   // until the next LOAD; pass_count resets at the end of each layer.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_count <= '0;
      end else if (load_en) begin
         cycle_count <= '0;
      end else if (cc_inc && (cycle_count != '1)) begin
         cycle_count <= cycle_count + CYC_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pass_count <= '0;
      end else if (pass_step) begin
         if (sh_q.last) pass_count <= '0;
         else           pass_count <= pass_count + PASS_CNT_WIDTH'(1);
      end
   end

   assign busy = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_pu_pass_sequencer.sv
// Directed bench for pu_pass_sequencer. Expected pass records and opsum
// writes go into queues as stimulus is driven; a negedge monitor pops them
// when the DUT raises pu_start / opsum_we_to_glb. cycle_count is narrowed
// to 4 bits so saturation is reachable.
module tb_pu_pass_sequencer;
   localparam int CW  = 96;
   localparam int AW  = 20;
   localparam int DW  = 16;
   localparam int DD  = 4;
   localparam int PW  = 8;
   localparam int CCW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          desc_valid, desc_ready;
   logic [CW-1:0] desc_cfg;
   logic [AW-1:0] desc_ifmap_base, desc_filter_base, desc_psum_base;
   logic          desc_relu, desc_last;
   logic [CW-1:0] pu_cfg;
   logic          pu_start, pu_done;
   logic [AW-1:0] pu_ifmap_addr, pu_filter_addr, pu_ipsum_addr, pu_bias_addr, pu_opsum_addr;
   logic [AW-1:0] ifmap_glb_addr, filter_glb_addr, ipsum_glb_addr, bias_glb_addr;
   logic          pu_opsum_we;
   logic [DW-1:0] pu_opsum_data;
   logic          opsum_we_to_glb;
   logic [AW-1:0] opsum_glb_addr;
   logic [DW-1:0] opsum_to_glb;
   logic          busy, layer_done;
   logic [PW-1:0] pass_count;
   logic [CCW-1:0] cycle_count;

   pu_pass_sequencer #(
      .CFG_WIDTH(CW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .DESC_FIFO_DEPTH(DD), .PASS_CNT_WIDTH(PW), .CYC_CNT_WIDTH(CCW)
   ) dut (
      .clk(clk), .reset(reset),
      .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_cfg(desc_cfg),
      .desc_ifmap_base(desc_ifmap_base), .desc_filter_base(desc_filter_base),
      .desc_psum_base(desc_psum_base), .desc_relu(desc_relu), .desc_last(desc_last),
      .pu_cfg(pu_cfg), .pu_start(pu_start), .pu_done(pu_done),
      .pu_ifmap_addr(pu_ifmap_addr), .pu_filter_addr(pu_filter_addr),
      .pu_ipsum_addr(pu_ipsum_addr), .pu_bias_addr(pu_bias_addr),
      .pu_opsum_addr(pu_opsum_addr),
      .ifmap_glb_addr(ifmap_glb_addr), .filter_glb_addr(filter_glb_addr),
      .ipsum_glb_addr(ipsum_glb_addr), .bias_glb_addr(bias_glb_addr),
      .pu_opsum_we(pu_opsum_we), .pu_opsum_data(pu_opsum_data),
      .opsum_we_to_glb(opsum_we_to_glb), .opsum_glb_addr(opsum_glb_addr),
      .opsum_to_glb(opsum_to_glb),
      .busy(busy), .layer_done(layer_done), .pass_count(pass_count),
      .cycle_count(cycle_count)
   );

   typedef struct {
      logic [CW-1:0] cfg;
      logic [AW-1:0] ib, fb, pb;
   } pass_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   pass_t exp_q[$];
   wr_t   op_q[$];
   pass_t cur_e;
   wr_t   mon_w;
   int    total = 0, bad = 0, n_start = 0, n_ld = 0;

   task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!reset) begin
         if (pu_start) begin
            n_start++;
            total++;
            assert (exp_q.size() > 0) else begin
               bad++;
               $error("FAIL start_unexpected: got pu_start with empty scoreboard, want none");
            end
            if (exp_q.size() > 0) begin
               cur_e = exp_q.pop_front();
               chk("pu_cfg_at_start", pu_cfg, cur_e.cfg);
            end
         end
         if (layer_done) n_ld++;
         if (opsum_we_to_glb) begin
            total++;
            assert (op_q.size() > 0) else begin
               bad++;
               $error("FAIL opsum_unexpected: got write addr 0x%0h, want none", opsum_glb_addr);
            end
            if (op_q.size() > 0) begin
               mon_w = op_q.pop_front();
               chk("opsum_addr", opsum_glb_addr, mon_w.a);
               chk("opsum_data", opsum_to_glb, mon_w.d);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [CW-1:0] cfg, input logic [AW-1:0] ib, fb, pb,
                       input logic relu, input logic last);
      int n = 0;
      desc_valid = 1'b1; desc_cfg = cfg;
      desc_ifmap_base = ib; desc_filter_base = fb; desc_psum_base = pb;
      desc_relu = relu; desc_last = last;
      while (!desc_ready && n < 50) begin cyc(); n++; end
      total++;
      assert (n < 50) else begin
         bad++;
         $error("FAIL push_timeout: got desc_ready=0 for %0d cycles, want 1", n);
      end
      exp_q.push_back('{cfg, ib, fb, pb});
      cyc();
      desc_valid = 1'b0;
   endtask

   task automatic wait_start();
      int n = 0;
      while (!pu_start && n < 30) begin cyc(); n++; end
      chk("start_timeout", pu_start, 1);
   endtask

   // Called in the first RUN cycle: checks relocation against the popped
   // record, runs hold more cycles, then raises pu_done for one cycle.
   task automatic finish_pass(input int hold, input logic [PW-1:0] exp_pc, input logic exp_ld);
      logic [AW-1:0] a, e;
      a = AW'($urandom);
      pu_ifmap_addr  = a;
      pu_filter_addr = a ^ 20'h5;
      #1;
      e = a + cur_e.ib;          chk("ifmap_reloc", ifmap_glb_addr, e);
      e = (a ^ 20'h5) + cur_e.fb; chk("filter_reloc", filter_glb_addr, e);
      repeat (hold) cyc();
      pu_done = 1'b1;
      cyc();
      pu_done = 1'b0;
      chk("layer_done_drain", layer_done, exp_ld);
      cyc();
      chk("pass_count", pass_count, exp_pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, l0;
      reset = 1'b1; desc_valid = 1'b0; desc_cfg = '0;
      desc_ifmap_base = '0; desc_filter_base = '0; desc_psum_base = '0;
      desc_relu = 1'b0; desc_last = 1'b0; pu_done = 1'b0;
      pu_ifmap_addr = '0; pu_filter_addr = '0; pu_ipsum_addr = '0;
      pu_bias_addr = '0; pu_opsum_addr = '0; pu_opsum_we = 1'b0; pu_opsum_data = '0;

      // Reset state
      repeat (3) cyc();
      chk("rst_pu_start", pu_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_desc_ready", desc_ready, 0);
      chk("rst_layer_done", layer_done, 0);
      chk("rst_pass_count", pass_count, 0);
      chk("rst_cycle_count", cycle_count, 0);
      chk("rst_opsum_we", opsum_we_to_glb, 0);
      chk("rst_pu_cfg", pu_cfg, 0);
      chk("rst_ifmap_addr", ifmap_glb_addr, 0);
      reset = 1'b0;
      #1;
      chk("ready_after_reset", desc_ready, 1);

      // Single pass, relocation, relu off
      push(96'hA5, 20'h100, 20'h200, 20'h300, 1'b0, 1'b1);
      chk("t1_busy", busy, 1);
      chk("t1_start_t1", pu_start, 0);
      cyc();
      chk("t1_start_load", pu_start, 0);
      cyc();
      chk("t1_start_t3", pu_start, 1);
      chk("t1_cfg_start", pu_cfg, 96'hA5);
      chk("t1_cc_start", cycle_count, 0);
      cyc();
      chk("t1_start_run", pu_start, 0);
      chk("t1_cc_run1", cycle_count, 1);
      pu_ifmap_addr = 20'h20; pu_filter_addr = 20'h5; pu_bias_addr = 20'h7; pu_ipsum_addr = 20'h9;
      pu_opsum_we = 1'b1; pu_opsum_addr = 20'h10; pu_opsum_data = 16'h8003;
      op_q.push_back('{20'h310, 16'h8003});
      #1;
      chk("t1_ifmap", ifmap_glb_addr, 20'h120);
      chk("t1_filter", filter_glb_addr, 20'h205);
      chk("t1_bias", bias_glb_addr, 20'h207);
      chk("t1_ipsum", ipsum_glb_addr, 20'h309);
      chk("t1_op_lat0", opsum_we_to_glb, 0);
      cyc();
      pu_opsum_we = 1'b0;
      chk("t1_op_lat1", opsum_we_to_glb, 1);
      chk("t1_cfg_run", pu_cfg, 96'hA5);
      cyc(); cyc();
      pu_done = 1'b1;
      chk("t1_cc_done", cycle_count, 4);
      cyc();
      pu_done = 1'b0;
      chk("t1_ld_drain", layer_done, 1);
      chk("t1_pc_drain", pass_count, 0);
      chk("t1_cc_drain", cycle_count, 5);
      cyc();
      chk("t1_ld_idle", layer_done, 0);
      chk("t1_busy_idle", busy, 0);
      chk("t1_cc_hold", cycle_count, 5);
      chk("t1_n_start", n_start, 1);

      // Address wrap + relu, write coincident with pu_done
      push(96'h11, 20'h0, 20'h0, 20'hFFFF0, 1'b1, 1'b1);
      wait_start();
      cyc();
      pu_opsum_we = 1'b1; pu_opsum_addr = 20'h20; pu_opsum_data = 16'h8003;
      op_q.push_back('{20'h00010, 16'h0000});
      cyc();
      pu_opsum_addr = 20'h21; pu_opsum_data = 16'h7FFF; pu_done = 1'b1;
      op_q.push_back('{20'h00011, 16'h7FFF});
      cyc();
      pu_opsum_we = 1'b0; pu_done = 1'b0;
      chk("t2_we_in_drain", opsum_we_to_glb, 1);
      chk("t2_addr_in_drain", opsum_glb_addr, 20'h00011);
      chk("t2_ld", layer_done, 1);
      cyc();

      // Queue: 4-pass layer then a 1-pass layer fills the FIFO
      for (int i = 0; i < 4; i++)
         push(96'h100 + CW'(i), AW'(i*4096 + 16), AW'(i*4096 + 32), AW'(i*4096 + 48), 1'b0, i == 3);
      push(96'h200, 20'h9000, 20'hA000, 20'hB000, 1'b0, 1'b1);
      chk("q_full_ready", desc_ready, 0);
      chk("q_busy", busy, 1);
      finish_pass(2, 1, 0);
      wait_start(); cyc(); finish_pass(1, 2, 0);
      wait_start(); cyc(); finish_pass(1, 3, 0);
      wait_start(); cyc(); finish_pass(1, 0, 1);
      wait_start(); cyc(); finish_pass(0, 0, 1);
      chk("q_n_ld", n_ld, 4);
      chk("q_n_start", n_start, 7);

      // Spurious pu_done in IDLE and START, mid-pass descriptor, saturation
      pu_done = 1'b1;
      cyc(); cyc();
      pu_done = 1'b0;
      chk("sp_idle_busy", busy, 0);
      chk("sp_idle_pc", pass_count, 0);
      chk("sp_idle_nld", n_ld, 4);
      push(96'h1111, 20'h40, 20'h50, 20'h60, 1'b0, 1'b1);
      wait_start();
      pu_done = 1'b1;
      cyc();
      pu_done = 1'b0;
      chk("sp_start_ld", layer_done, 0);
      push(96'h2222, 20'h70, 20'h80, 20'h90, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("mid_cfg_hold", pu_cfg, 96'h1111);
         cyc();
      end
      finish_pass(12, 0, 1);
      chk("cc_saturate", cycle_count, 4'hF);
      wait_start();
      chk("cc_cleared", cycle_count, 0);
      cyc();
      finish_pass(0, 0, 1);

      // Reset in RUN with two queued descriptors and an in-flight write
      push(96'h3333, 20'h1, 20'h2, 20'h3, 1'b0, 1'b0);
      wait_start();
      cyc();
      push(96'h4444, 20'h4, 20'h5, 20'h6, 1'b0, 1'b1);
      push(96'h5555, 20'h7, 20'h8, 20'h9, 1'b0, 1'b1);
      s0 = n_start; l0 = n_ld;
      pu_opsum_we = 1'b1; pu_opsum_data = 16'h1234;
      reset = 1'b1;
      cyc();
      pu_opsum_we = 1'b0;
      exp_q.delete();
      chk("rr_busy", busy, 0);
      chk("rr_we", opsum_we_to_glb, 0);
      chk("rr_start", pu_start, 0);
      chk("rr_ld", layer_done, 0);
      chk("rr_cfg", pu_cfg, 0);
      reset = 1'b0;
      repeat (10) cyc();
      chk("rr_no_start", n_start, s0);
      chk("rr_no_ld", n_ld, l0);
      chk("rr_busy_after", busy, 0);
      chk("rr_pc", pass_count, 0);

      chk("sb_pass_empty", exp_q.size(), 0);
      chk("sb_op_empty", op_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
